// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  // Quotient reported when the divisor is zero. It is sign-extended to the instance width.
  localparam logic [DIV_DATA_W-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/seq_restoring_div_if.sv
// Start/busy/done handshake and operand/result bus of the restoring divider.
interface seq_restoring_div_if #(
  parameter int unsigned DATA_W = 32
);

  logic              start;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;
  logic              div_by_zero;

  // Operand-load side: issues requests and consumes results.
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_sign_chk.sv
// Sign checker for the trial subtraction: flags a negative or non-negative trial value.
module div_sign_chk #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W:0] trial,
  output logic            neg,
  output logic            pos
);

  // Exactly one of neg/pos is high for any trial value.
  always_comb begin
    neg = ($signed(trial) < $signed((DATA_W + 1)'(0)));
    pos = !neg;
  end

endmodule

// File: rtl/seq_restoring_div.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
module seq_restoring_div
  import div_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W,
  parameter int unsigned CNT_W  = 6
) (
  input logic                clk,
  input logic                rst,
  seq_restoring_div_if.slave bus
);

  div_state_e        state_q, state_d;
  logic [DATA_W:0]   a_q, a_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] quotient_q, quotient_d;
  logic [DATA_W-1:0] remainder_q, remainder_d;
  logic              div_by_zero_q, div_by_zero_d;

  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;
  logic              neg;
  logic              pos;

  // Shift A:Q left by one and trial-subtract the zero-extended divisor.
  always_comb begin
    // A's top bit is always 0 between iterations, so dropping it loses nothing.
    shifted = (DATA_W + 1)'({a_q, q_q[DATA_W-1]});
    trial   = shifted - {1'b0, m_q};
  end

  div_sign_chk #(
    .DATA_W (DATA_W)
  ) u_sign_chk (
    .trial (trial),
    .neg   (neg),
    .pos   (pos)
  );

  // Control FSM next-state and datapath updates.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    q_d           = q_q;
    m_d           = m_q;
    count_d       = count_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.divisor != '0) begin
            a_d     = '0;
            q_d     = bus.dividend;
            m_d     = bus.divisor;
            count_d = CNT_W'(DATA_W);
            state_d = S_RUN;
          end else begin
            quotient_d    = DATA_W'($signed(DIV_ZERO_QUOT));
            remainder_d   = bus.dividend;
            div_by_zero_d = 1'b1;
            state_d       = S_DONE;
          end
        end
      end

      S_RUN: begin
        unique case ({neg, pos})
          2'b01: begin
            a_d = trial;
            q_d = {q_q[DATA_W-2:0], 1'b1};
          end
          2'b10: begin
            a_d = shifted;
            q_d = {q_q[DATA_W-2:0], 1'b0};
          end
          default: begin
            a_d = shifted;
            q_d = {q_q[DATA_W-2:0], 1'b0};
          end
        endcase
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          quotient_d    = q_d;
          remainder_d   = a_d[DATA_W-1:0];
          div_by_zero_d = 1'b0;
          state_d       = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      a_q           <= '0;
      q_q           <= '0;
      m_q           <= '0;
      count_q       <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      q_q           <= q_d;
      m_q           <= m_d;
      count_q       <= count_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  // Handshake flags decode directly from the state.
  always_comb begin
    bus.busy        = (state_q != S_IDLE);
    bus.done        = (state_q == S_DONE);
    bus.quotient    = quotient_q;
    bus.remainder   = remainder_q;
    bus.div_by_zero = div_by_zero_q;
  end

endmodule

// File: tb/tb_seq_restoring_div.sv
// Directed and random bench for seq_restoring_div.
module tb_seq_restoring_div;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   done_cnt;

  seq_restoring_div_if #(.DATA_W(32)) bus ();

  seq_restoring_div #(
    .DATA_W (32),
    .CNT_W  (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of cycles that done was seen high at a rising edge.
  always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; presents one start pulse.
  task automatic start_op(input logic [31:0] dvd, input logic [31:0] dvs);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Counts negedges until done is seen, bounded.
  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_done_seen"}, 32'(bus.done), 32'd1);
  endtask

  task automatic chk_result(input string tag, input logic [31:0] q, input logic [31:0] r,
                            input logic dz);
    chk({tag, "_quot"}, bus.quotient, q);
    chk({tag, "_rem"}, bus.remainder, r);
    chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(dz));
  endtask

  initial begin
    int          lat;
    int          snap;
    logic [31:0] a;
    logic [31:0] b;

    checks       = 0;
    errors       = 0;
    done_cnt     = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk_result("reset", 32'd0, 32'd0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Basic 100/7 with latency and pulse width.
    start_op(32'd100, 32'd7);
    chk("basic_busy", 32'(bus.busy), 32'd1);
    chk("basic_not_done", 32'(bus.done), 32'd0);
    wait_done("basic", lat);
    chk("basic_latency", 32'(lat), 32'd32);
    chk_result("basic", 32'd14, 32'd2, 1'b0);
    @(negedge clk);
    chk("basic_done_drop", 32'(bus.done), 32'd0);
    chk("basic_busy_drop", 32'(bus.busy), 32'd0);

    // Asynchronous reset in the middle of a run.
    start_op(32'd100, 32'd7);
    repeat (10) @(negedge clk);
    snap = done_cnt;
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk_result("abort", 32'd0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'(snap));
    chk("abort_idle", 32'(bus.busy), 32'd0);
    start_op(32'd100, 32'd7);
    wait_done("after_abort", lat);
    chk_result("after_abort", 32'd14, 32'd2, 1'b0);
    @(negedge clk);

    // Back-to-back extremes with start held high.
    bus.start    = 1'b1;
    bus.dividend = 32'hFFFF_FFFF;
    bus.divisor  = 32'd1;
    @(negedge clk);
    chk("b2b1_busy", 32'(bus.busy), 32'd1);
    bus.dividend = 32'd5;
    bus.divisor  = 32'd9;
    wait_done("b2b1", lat);
    chk("b2b1_latency", 32'(lat), 32'd32);
    chk_result("b2b1", 32'hFFFF_FFFF, 32'd0, 1'b0);
    @(negedge clk);
    chk("b2b1_pulse", 32'(bus.done), 32'd0);
    chk("b2b1_gap_idle", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("b2b2_accept", 32'(bus.busy), 32'd1);
    bus.dividend = 32'hFFFF_FFFF;
    bus.divisor  = 32'hFFFF_FFFF;
    wait_done("b2b2", lat);
    chk("b2b2_latency", 32'(lat), 32'd32);
    chk_result("b2b2", 32'd0, 32'd5, 1'b0);
    @(negedge clk);
    chk("b2b2_pulse", 32'(bus.done), 32'd0);
    chk("b2b2_gap_idle", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("b2b3_accept", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    wait_done("b2b3", lat);
    chk("b2b3_latency", 32'(lat), 32'd32);
    chk_result("b2b3", 32'd1, 32'd0, 1'b0);
    @(negedge clk);
    chk("b2b3_pulse", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("b2b_stop", 32'(bus.busy), 32'd0);

    // Divide by zero, then a normal operation clears the flag.
    start_op(32'd1234, 32'd0);
    wait_done("dbz", lat);
    chk("dbz_latency", 32'(lat), 32'd0);
    chk_result("dbz", 32'hFFFF_FFFF, 32'd1234, 1'b1);
    @(negedge clk);
    chk("dbz_pulse", 32'(bus.done), 32'd0);
    chk("dbz_idle", 32'(bus.busy), 32'd0);
    chk("dbz_hold", 32'(bus.div_by_zero), 32'd1);
    start_op(32'd10, 32'd3);
    wait_done("post_dbz", lat);
    chk_result("post_dbz", 32'd3, 32'd1, 1'b0);
    @(negedge clk);

    // Start pulse while busy must be ignored.
    snap = done_cnt;
    start_op(32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    start_op(32'd50, 32'd5);
    wait_done("busy_start", lat);
    chk_result("busy_start", 32'd333, 32'd1, 1'b0);
    repeat (4) @(negedge clk);
    chk("busy_start_one_done", 32'(done_cnt - snap), 32'd1);
    chk("busy_start_idle", 32'(bus.busy), 32'd0);

    // Random operands against the native divide.
    for (int i = 0; i < 2000; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (b == 32'd0) b = 32'd1;
      start_op(a, b);
      wait_done("rand", lat);
      chk("rand_quot", bus.quotient, a / b);
      chk("rand_rem", bus.remainder, a % b);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
